// File: rtl/tmiv_hssaer_word_dec.sv
// TMIV word decoder for the HSSAER receive path.
// Stage 1 sorts each measured interval into a data symbol, the delimiter, or
// an invalid code, and registers the result as the raw symbol stream.
// Stage 2 is a HUNT/COLLECT framer. It shifts delimiter-framed data symbols
// into a word and places each finished word in a one-entry valid/ready
// buffer. Error events are counted in a saturating counter.
module tmiv_hssaer_word_dec #(
  parameter  int DW            = 5,
  parameter  int DBITS         = 2,
  parameter  int BIN_BASE      = 2,
  parameter  int BIN_STEP      = 3,
  parameter  int SYMS_PER_WORD = 4,
  parameter  int ECNT_W        = 8,
  localparam int NSYM          = (2 ** DBITS) + 1,
  localparam int SW            = DBITS + 1,
  localparam int WORD_W        = DBITS * SYMS_PER_WORD
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic [DW-1:0]     tmiv_d,
  input  logic              tmiv_st,
  input  logic              tmiv_err,
  output logic [SW-1:0]     tvr_d,
  output logic              tvr_st,
  output logic              tvr_err,
  output logic [WORD_W-1:0] word_d,
  output logic              word_vld,
  input  logic              word_rdy,
  output logic              ovf,
  output logic [ECNT_W-1:0] err_cnt,
  input  logic              err_clr
);

  localparam int CW = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;

  localparam logic [SW-1:0] SYM_INV   = '1;
  localparam logic [SW-1:0] SYM_DELIM = SW'(2 ** DBITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SYMS_PER_WORD - 1);

  // Reject parameter sets where the bins overflow the interval range, where a
  // bin is empty, or where the delimiter would collide with the invalid code.
  generate
    if ((BIN_BASE + NSYM * BIN_STEP > 2 ** DW) || (BIN_STEP < 1) ||
        (BIN_BASE < 0) || (DBITS < 1) || (SYMS_PER_WORD < 2) || (ECNT_W < 1)) begin : g_bad_params
      $error("tmiv_hssaer_word_dec: invalid parameter set");
    end
  endgenerate

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] shreg;

  logic [SW-1:0]     sym_nxt;
  logic              is_inv;
  logic              is_delim;
  logic              is_data;
  logic              err_ev;
  logic              frame_err;
  logic              word_done;
  logic              drop;
  logic [WORD_W-1:0] word_new;

  // Bin lookup: compare the interval against every symbol bin's bounds.
  // NOTE: sym_nxt receives a default before the loop. This covers every path
  // through the block, so it stays combinational and no latch is inferred.
  always_comb begin
    sym_nxt = SYM_INV;
    for (int k = 0; k < NSYM; k++) begin
      if ((int'(tmiv_d) >= BIN_BASE + k * BIN_STEP) &&
          (int'(tmiv_d) <  BIN_BASE + (k + 1) * BIN_STEP)) begin
        sym_nxt = SW'(k);
      end
    end
  end

  // Stage 1 register. The raw symbol is held between strobes; strobe and error are plain delays.
  // NOTE: state registers use non-blocking assignments. Every flop then samples its
  // pre-edge inputs, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      tvr_d   <= '0;
      tvr_st  <= 1'b0;
      tvr_err <= 1'b0;
    end else begin
      tvr_st  <= tmiv_st;
      tvr_err <= tmiv_err;
      if (tmiv_st) begin
        tvr_d <= sym_nxt;
      end
    end
  end

  // Classify the stage-1 symbol and derive the framing and buffer events.
  always_comb begin
    is_inv    = tvr_st && (tvr_d == SYM_INV);
    is_delim  = tvr_st && (tvr_d == SYM_DELIM);
    is_data   = tvr_st && (tvr_d < SYM_DELIM);
    err_ev    = is_inv || tvr_err;
    frame_err = (state == COLLECT) && !err_ev && is_delim && (cnt != '0);
    word_done = (state == COLLECT) && !err_ev && is_data && (cnt == CNT_LAST);
    drop      = word_done && word_vld && !word_rdy;
    word_new  = {shreg[WORD_W-DBITS-1:0], tvr_d[DBITS-1:0]};
  end

  // Framer FSM and one-word output buffer. A word that completes while the
  // buffer is still occupied and not being read is dropped and flagged in ovf.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state    <= HUNT;
      cnt      <= '0;
      shreg    <= '0;
      word_d   <= '0;
      word_vld <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (!err_ev && is_delim) begin
            state <= COLLECT;
            cnt   <= '0;
          end
        end
        COLLECT: begin
          if (err_ev) begin
            state <= HUNT;
            cnt   <= '0;
          end else if (is_delim) begin
            cnt <= '0;
          end else if (is_data) begin
            shreg <= word_new;
            if (cnt == CNT_LAST) begin
              state <= HUNT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= HUNT;
          cnt   <= '0;
        end
      endcase

      if (word_done && (!word_vld || word_rdy)) begin
        word_d   <= word_new;
        word_vld <= 1'b1;
      end else if (word_vld && word_rdy) begin
        word_vld <= 1'b0;
      end

      if (err_clr) begin
        ovf <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Saturating error counter. A clear wins over an event in the same cycle.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if ((err_ev || frame_err) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ECNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tmiv_hssaer_word_dec.sv
// Directed bench for tmiv_hssaer_word_dec. A second instance with a 2-bit
// error counter shares the inputs, so counter saturation can be observed.
module tb_tmiv_hssaer_word_dec;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] tmiv_d = '0;
  logic       tmiv_st = 1'b0;
  logic       tmiv_err = 1'b0;
  logic       word_rdy = 1'b0;
  logic       err_clr = 1'b0;

  logic [2:0] tvr_d;
  logic       tvr_st, tvr_err, word_vld, ovf;
  logic [7:0] word_d, err_cnt;

  logic [2:0] s_tvr_d;
  logic       s_tvr_st, s_tvr_err, s_word_vld, s_ovf;
  logic [7:0] s_word_d;
  logic [1:0] s_err_cnt;

  int         checks = 0;
  int         errors = 0;
  int         nwords = 0;
  logic [7:0] last_word = '0;

  tmiv_hssaer_word_dec dut (
    .clk(clk), ._rst(rst_n), .tmiv_d(tmiv_d), .tmiv_st(tmiv_st), .tmiv_err(tmiv_err),
    .tvr_d(tvr_d), .tvr_st(tvr_st), .tvr_err(tvr_err), .word_d(word_d),
    .word_vld(word_vld), .word_rdy(word_rdy), .ovf(ovf), .err_cnt(err_cnt),
    .err_clr(err_clr)
  );

  tmiv_hssaer_word_dec #(.ECNT_W(2)) dut_sat (
    .clk(clk), ._rst(rst_n), .tmiv_d(tmiv_d), .tmiv_st(tmiv_st), .tmiv_err(tmiv_err),
    .tvr_d(s_tvr_d), .tvr_st(s_tvr_st), .tvr_err(s_tvr_err), .word_d(s_word_d),
    .word_vld(s_word_vld), .word_rdy(word_rdy), .ovf(s_ovf), .err_cnt(s_err_cnt),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Record every handshake, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    if (word_vld && word_rdy) begin
      nwords++;
      last_word = word_d;
    end
  end

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One interval strobe. Consecutive calls give back-to-back symbols.
  task automatic send(input int d);
    tmiv_d  = 5'(d);
    tmiv_st = 1'b1;
    cycle();
    tmiv_st = 1'b0;
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({tvr_d, tvr_st, tvr_err, word_d, word_vld, ovf, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got tvr_d=%0d word_d=%0h vld=%0b ovf=%0b err_cnt=%0d, expected all 0",
               tvr_d, word_d, word_vld, ovf, err_cnt);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_classify();
    int ivals[13] = '{2, 4, 5, 7, 8, 10, 11, 13, 14, 16, 1, 17, 31};
    int exps[13]  = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 7, 7, 7};
    for (int i = 0; i < 13; i++) begin
      tmiv_d  = 5'(ivals[i]);
      tmiv_st = 1'b1;
      cycle();
      tmiv_st = 1'b0;
      @(negedge clk);
      checks++;
      if (tvr_d !== 3'(exps[i]) || tvr_st !== 1'b1) begin
        errors++;
        $display("FAIL classify_%0d: got tvr_d=%0d tvr_st=%0b, expected tvr_d=%0d tvr_st=1",
                 ivals[i], tvr_d, tvr_st, exps[i]);
      end
    end
    cycle();
    @(negedge clk);
    checks++;
    if (tvr_d !== 3'd7 || tvr_st !== 1'b0) begin
      errors++;
      $display("FAIL classify_hold: got tvr_d=%0d tvr_st=%0b, expected 7 and 0", tvr_d, tvr_st);
    end
    idle(2);
    checks++;
    if (err_cnt !== 8'd3) begin
      errors++;
      $display("FAIL classify_err_cnt: got %0d expected 3", err_cnt);
    end
  endtask

  task automatic test_word();
    int n0;
    err_clear();
    word_rdy = 1'b1;
    n0 = nwords;
    send(15); send(3); send(6); send(9);
    tmiv_d  = 5'd12;
    tmiv_st = 1'b1;
    cycle();
    tmiv_st = 1'b0;
    @(negedge clk);
    checks++;
    if (word_vld !== 1'b0) begin
      errors++;
      $display("FAIL word_early: got vld=%0b expected 0", word_vld);
    end
    cycle();
    @(negedge clk);
    checks++;
    if (word_vld !== 1'b1 || word_d !== 8'h1b) begin
      errors++;
      $display("FAIL word_value: got vld=%0b word=%0h expected 1 and 1b", word_vld, word_d);
    end
    cycle();
    @(negedge clk);
    checks++;
    if (word_vld !== 1'b0 || nwords !== n0 + 1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL word_once: got vld=%0b words=%0d err_cnt=%0d expected 0, %0d, 0",
               word_vld, nwords - n0, err_cnt, 1);
    end
  endtask

  task automatic test_frame_err();
    int n0;
    err_clear();
    n0 = nwords;
    send(15); send(6); send(9); send(15);
    send(3); send(3); send(3); send(3);
    idle(3);
    checks++;
    if (err_cnt !== 8'd1 || nwords !== n0 + 1 || last_word !== 8'h00) begin
      errors++;
      $display("FAIL frame_err: got err_cnt=%0d words=%0d word=%0h expected 1, 1, 00",
               err_cnt, nwords - n0, last_word);
    end
  endtask

  task automatic test_invalid();
    int n0;
    err_clear();
    n0 = nwords;
    send(15); send(6); send(30); send(6); send(9); send(12);
    idle(3);
    checks++;
    if (err_cnt !== 8'd1 || nwords !== n0) begin
      errors++;
      $display("FAIL invalid_abort: got err_cnt=%0d words=%0d expected 1, 0", err_cnt, nwords - n0);
    end
    send(15); send(3); send(6); send(9); send(12);
    idle(3);
    checks++;
    if (nwords !== n0 + 1 || last_word !== 8'h1b || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL invalid_recover: got words=%0d word=%0h err_cnt=%0d expected 1, 1b, 1",
               nwords - n0, last_word, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    err_clear();
    word_rdy = 1'b0;
    send(15); send(3); send(3); send(3); send(6);
    idle(3);
    checks++;
    if (word_vld !== 1'b1 || word_d !== 8'h01 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got vld=%0b word=%0h ovf=%0b expected 1, 01, 0", word_vld, word_d, ovf);
    end
    send(15); send(12); send(12); send(12); send(12);
    idle(3);
    checks++;
    if (word_vld !== 1'b1 || word_d !== 8'h01 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf: got vld=%0b word=%0h ovf=%0b expected 1, 01, 1", word_vld, word_d, ovf);
    end
    send(15); send(9); send(9); send(9);
    tmiv_d  = 5'd9;
    tmiv_st = 1'b1;
    cycle();
    tmiv_st  = 1'b0;
    word_rdy = 1'b1;
    cycle();
    word_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (word_vld !== 1'b1 || word_d !== 8'haa || ovf !== 1'b1 || last_word !== 8'h01) begin
      errors++;
      $display("FAIL bp_same_cycle: got vld=%0b word=%0h ovf=%0b taken=%0h expected 1, aa, 1, 01",
               word_vld, word_d, ovf, last_word);
    end
    err_clear();
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0 || word_vld !== 1'b1) begin
      errors++;
      $display("FAIL bp_clear: got ovf=%0b vld=%0b expected 0, 1", ovf, word_vld);
    end
    word_rdy = 1'b1;
    cycle();
    word_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (word_vld !== 1'b0 || last_word !== 8'haa) begin
      errors++;
      $display("FAIL bp_drain: got vld=%0b taken=%0h expected 0, aa", word_vld, last_word);
    end
  endtask

  task automatic test_err_cnt();
    err_clear();
    tmiv_err = 1'b1;
    cycle();
    @(negedge clk);
    checks++;
    if (tvr_err !== 1'b1) begin
      errors++;
      $display("FAIL tvr_err: got %0b expected 1", tvr_err);
    end
    cycle();
    tmiv_err = 1'b0;
    idle(2);
    checks++;
    if (err_cnt !== 8'd2 || s_err_cnt !== 2'd2) begin
      errors++;
      $display("FAIL err_count: got %0d/%0d expected 2/2", err_cnt, s_err_cnt);
    end
    tmiv_err = 1'b1;
    idle(3);
    tmiv_err = 1'b0;
    idle(2);
    checks++;
    if (err_cnt !== 8'd5 || s_err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL err_saturate: got %0d/%0d expected 5/3", err_cnt, s_err_cnt);
    end
    tmiv_err = 1'b1;
    cycle();
    tmiv_err = 1'b0;
    err_clr  = 1'b1;
    cycle();
    err_clr  = 1'b0;
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'd0 || s_err_cnt !== 2'd0) begin
      errors++;
      $display("FAIL err_clr_priority: got %0d/%0d expected 0/0", err_cnt, s_err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    word_rdy = 1'b0;
    send(15); send(3); send(6); send(9); send(12);
    idle(3);
    checks++;
    if (word_vld !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_buffer: got vld=%0b expected 1", word_vld);
    end
    send(15); send(3);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({tvr_d, tvr_st, tvr_err, word_d, word_vld, ovf, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_async: got tvr_d=%0d tvr_st=%0b word=%0h vld=%0b ovf=%0b err_cnt=%0d, expected all 0",
               tvr_d, tvr_st, word_d, word_vld, ovf, err_cnt);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle();
    word_rdy = 1'b1;
    n0 = nwords;
    send(15); send(6); send(6); send(6); send(6);
    idle(3);
    checks++;
    if (nwords !== n0 + 1 || last_word !== 8'h55 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_recover: got words=%0d word=%0h err_cnt=%0d expected 1, 55, 0",
               nwords - n0, last_word, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_word();
    test_frame_err();
    test_invalid();
    test_backpressure();
    test_err_cnt();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
